// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared definitions for the in-place radix-2 DIT FFT
//                controller: FSM state encoding and pipeline latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    // Working-memory and twiddle-ROM read latency, in clock cycles.
    localparam int MEM_RD_LAT   = 1;
    // Butterfly unit latency, in clock cycles.
    localparam int BF_LAT       = 1;
    // Cycles spent flushing the pipeline between stages.
    localparam int DRAIN_CYCLES = 2;
    // Issue-to-write-back distance; the controller's delay line is this deep.
    localparam int PIPE_DEPTH   = MEM_RD_LAT + BF_LAT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fft_state_t;

endpackage
`default_nettype wire

// File: rtl/fft_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : fft_addr_gen
//  Description : Combinational butterfly address generator for an in-place
//                radix-2 DIT FFT of length N = 2**LOG2_N.
//                  s       : stage index
//                  k       : butterfly index within the stage (0..N/2-1)
//                  addr_a  : upper leg address   (grp*2*span + pos)
//                  addr_b  : lower leg address   (addr_a + span)
//                  tw_addr : twiddle ROM index   (pos << (LOG2_N-1-s))
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2_N = 8,
    parameter int STG_W  = 3
) (
    input  logic [STG_W-1:0]  s,
    input  logic [LOG2_N-2:0] k,
    output logic [LOG2_N-1:0] addr_a,
    output logic [LOG2_N-1:0] addr_b,
    output logic [LOG2_N-2:0] tw_addr
);

    localparam logic [LOG2_N-1:0] c_ONE    = LOG2_N'(1);
    localparam logic [LOG2_N-2:0] c_K_ONES = '1;
    localparam logic [STG_W-1:0]  c_TW_TOP = STG_W'(LOG2_N - 1);

    logic [LOG2_N-1:0] w_span;
    logic [LOG2_N-2:0] w_mask;
    logic [LOG2_N-2:0] w_pos;
    logic [LOG2_N-2:0] w_grp_bits;
    logic [STG_W-1:0]  w_tw_sh;

    // span-1 built directly in k's width: shifting all-ones left by s and
    // inverting yields s low ones, and saturates to all-ones at the last
    // stage without needing a wider intermediate.
    assign w_span     = c_ONE << s;
    assign w_mask     = ~(c_K_ONES << s);
    assign w_pos      = k & w_mask;
    assign w_grp_bits = k & ~w_mask;

    // grp*2*span == (k with low s bits cleared) << 1; bit s of addr_a is
    // therefore always 0, so adding span reduces to setting that bit.
    assign addr_a  = {w_grp_bits, 1'b0} | {1'b0, w_pos};
    assign addr_b  = addr_a | w_span;

    assign w_tw_sh = c_TW_TOP - s;
    assign tw_addr = w_pos << w_tw_sh;

endmodule
`default_nettype wire

// File: rtl/fft_controller.sv
`default_nettype none
// ============================================================================
//  Module      : fft_controller
//  Description : Sequencer for an in-place radix-2 DIT FFT (bit-reversed in,
//                natural order out). Issues one butterfly per cycle, drains
//                the read/compute/write pipeline between stages and pulses
//                done on completion.
//  Ports       : clk, rst          clock / synchronous active-high reset
//                start, hold       transform request / issue stall
//                busy, done        RUN|DRAIN flag / 1-cycle completion pulse
//                rd_en, rd_addr_*  butterfly pair read, tw_addr twiddle index
//                bf_en             butterfly enable (rd_en + 1 cycle)
//                wr_en, wr_addr_*  in-place write-back (rd_en + 2 cycles)
//                stage             current stage while busy, else 0
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_controller
    import fft_pkg::*;
#(
    parameter int LOG2_N = 8,
    parameter int STG_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [LOG2_N-1:0] rd_addr_a,
    output logic [LOG2_N-1:0] rd_addr_b,
    output logic [LOG2_N-2:0] tw_addr,
    output logic              bf_en,
    output logic              wr_en,
    output logic [LOG2_N-1:0] wr_addr_a,
    output logic [LOG2_N-1:0] wr_addr_b,
    output logic [STG_W-1:0]  stage
);

    localparam int                c_DRN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [c_DRN_W-1:0] c_DRN_LAST = c_DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [c_DRN_W-1:0] c_DRN_ONE  = c_DRN_W'(1);
    localparam logic [LOG2_N-2:0] c_K_LAST   = '1;
    localparam logic [LOG2_N-2:0] c_K_ONE    = (LOG2_N - 1)'(1);
    localparam logic [STG_W-1:0]  c_S_LAST   = STG_W'(LOG2_N - 1);
    localparam logic [STG_W-1:0]  c_S_ONE    = STG_W'(1);

    fft_state_t        r_state;
    fft_state_t        w_state_nxt;
    logic [STG_W-1:0]  r_s;
    logic [STG_W-1:0]  w_s_nxt;
    logic [LOG2_N-2:0] r_k;
    logic [LOG2_N-2:0] w_k_nxt;
    logic [c_DRN_W-1:0] r_drn;
    logic [c_DRN_W-1:0] w_drn_nxt;
    logic              w_issue;

    logic [LOG2_N-1:0] w_ag_a;
    logic [LOG2_N-1:0] w_ag_b;
    logic [LOG2_N-2:0] w_ag_tw;

    // Issue-to-write-back delay line of {valid, addr_a, addr_b}.
    logic              r_vld [PIPE_DEPTH];
    logic [LOG2_N-1:0] r_pa  [PIPE_DEPTH];
    logic [LOG2_N-1:0] r_pb  [PIPE_DEPTH];

    fft_addr_gen #(
        .LOG2_N (LOG2_N),
        .STG_W  (STG_W)
    ) u_addr_gen (
        .s       (r_s),
        .k       (r_k),
        .addr_a  (w_ag_a),
        .addr_b  (w_ag_b),
        .tw_addr (w_ag_tw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_k     <= '0;
            r_drn   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_k     <= w_k_nxt;
            r_drn   <= w_drn_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_k_nxt     = r_k;
        w_drn_nxt   = r_drn;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_s_nxt     = '0;
                    w_k_nxt     = '0;
                end
            end
            ST_RUN: begin
                if (!hold) begin
                    w_issue = 1'b1;
                    if (r_k == c_K_LAST) begin
                        // k parks on its last value; it is only cleared by
                        // the stage transition out of DRAIN.
                        w_state_nxt = ST_DRAIN;
                        w_drn_nxt   = '0;
                    end else begin
                        w_k_nxt = r_k + c_K_ONE;
                    end
                end
            end
            ST_DRAIN: begin
                // Leaving DRAIN after PIPE_DEPTH cycles puts the next stage's
                // first read one cycle after this stage's last write.
                if (r_drn == c_DRN_LAST) begin
                    if (r_s == c_S_LAST) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_s_nxt     = r_s + c_S_ONE;
                        w_k_nxt     = '0;
                    end
                end else begin
                    w_drn_nxt = r_drn + c_DRN_ONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_s_nxt     = '0;
                w_k_nxt     = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                r_vld[i] <= 1'b0;
                r_pa[i]  <= '0;
                r_pb[i]  <= '0;
            end
        end else begin
            r_vld[0] <= w_issue;
            r_pa[0]  <= rd_addr_a;
            r_pb[0]  <= rd_addr_b;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_pa[i]  <= r_pa[i-1];
                r_pb[i]  <= r_pb[i-1];
            end
        end
    end

    assign busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done      = (r_state == ST_DONE);
    assign stage     = busy ? r_s : '0;

    // Addresses are forced to 0 outside an issue cycle so idle outputs and
    // write-back addresses of empty pipeline slots read as 0.
    assign rd_en     = w_issue;
    assign rd_addr_a = w_issue ? w_ag_a  : '0;
    assign rd_addr_b = w_issue ? w_ag_b  : '0;
    assign tw_addr   = w_issue ? w_ag_tw : '0;

    assign bf_en     = r_vld[MEM_RD_LAT-1];
    assign wr_en     = r_vld[PIPE_DEPTH-1];
    assign wr_addr_a = r_pa[PIPE_DEPTH-1];
    assign wr_addr_b = r_pb[PIPE_DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_fft_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_controller
//  Description : Self-checking bench for fft_controller at LOG2_N=3.
//                Expected read/write events are queued when a transform is
//                planned and popped as the DUT produces them; a memory and
//                butterfly model checks the end-to-end impulse response.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_controller;

    localparam int c_LOG2_N = 3;
    localparam int c_STG_W  = 2;
    localparam int c_AMP    = 1000;
    localparam int c_HORIZ  = 128;

    logic       clk;
    logic       rst;
    logic       start;
    logic       hold;
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [2:0] rd_addr_a;
    logic [2:0] rd_addr_b;
    logic [1:0] tw_addr;
    logic       bf_en;
    logic       wr_en;
    logic [2:0] wr_addr_a;
    logic [2:0] wr_addr_b;
    logic [1:0] stage;

    fft_controller #(
        .LOG2_N (c_LOG2_N),
        .STG_W  (c_STG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .hold      (hold),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .bf_en     (bf_en),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .stage     (stage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------- checker
    int n_cmp;
    int n_err;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------- scoreboard
    typedef struct {
        int c;
        int a;
        int b;
        int tw;
        int stg;
    } ev_t;

    ev_t exp_rd[$];
    ev_t exp_wr[$];
    bit  exp_bf_at   [c_HORIZ];
    bit  exp_busy_at [c_HORIZ];
    bit  exp_done_at [c_HORIZ];

    // Butterfly pairs and twiddles for N=8, stage-major.
    int tab_a  [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int tab_b  [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int tab_tw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

    int t0;
    bit mon_on;

    task automatic clear_sb();
        exp_rd.delete();
        exp_wr.delete();
        for (int i = 0; i < c_HORIZ; i++) begin
            exp_bf_at[i]   = 1'b0;
            exp_busy_at[i] = 1'b0;
            exp_done_at[i] = 1'b0;
        end
    endtask

    // Queue the expected activity of one transform whose start is sampled in
    // cycle st; hc is a single RUN hold cycle (-1: none), ab the last cycle
    // before a reset takes effect (-1: no reset).
    task automatic plan(input int st, input int hc, input int ab);
        int  t;
        int  idx;
        ev_t e;
        t   = st + 1;
        idx = 0;
        for (int s = 0; s < c_LOG2_N; s++) begin
            for (int k = 0; k < 4; k++) begin
                if (t == hc) t++;
                e.c = t; e.a = tab_a[idx]; e.b = tab_b[idx]; e.tw = tab_tw[idx]; e.stg = s;
                if (ab < 0 || t <= ab) exp_rd.push_back(e);
                if (ab < 0 || t + 1 <= ab) exp_bf_at[t+1] = 1'b1;
                e.c = t + 2;
                if (ab < 0 || t + 2 <= ab) exp_wr.push_back(e);
                t++;
                idx++;
            end
            t += 2;
        end
        if (ab < 0 || t <= ab) exp_done_at[t] = 1'b1;
        for (int c = st + 1; c < t; c++)
            if (ab < 0 || c <= ab) exp_busy_at[c] = 1'b1;
    endtask

    int  rel;
    ev_t pe;
    bit  e_rd;
    bit  e_wr;

    always @(negedge clk) begin
        if (mon_on) begin
            rel  = cyc - t0;
            e_rd = 1'b0;
            e_wr = 1'b0;
            if (exp_rd.size() > 0) if (exp_rd[0].c == rel) e_rd = 1'b1;
            if (exp_wr.size() > 0) if (exp_wr[0].c == rel) e_wr = 1'b1;
            chk("rd_en", int'(rd_en), int'(e_rd));
            if (e_rd) begin
                pe = exp_rd.pop_front();
                chk("rd_addr_a", int'(rd_addr_a), pe.a);
                chk("rd_addr_b", int'(rd_addr_b), pe.b);
                chk("tw_addr",   int'(tw_addr),   pe.tw);
                chk("stage",     int'(stage),     pe.stg);
            end
            chk("wr_en", int'(wr_en), int'(e_wr));
            if (e_wr) begin
                pe = exp_wr.pop_front();
                chk("wr_addr_a", int'(wr_addr_a), pe.a);
                chk("wr_addr_b", int'(wr_addr_b), pe.b);
            end
            if (rel >= 0 && rel < c_HORIZ) begin
                chk("bf_en", int'(bf_en), int'(exp_bf_at[rel]));
                chk("busy",  int'(busy),  int'(exp_busy_at[rel]));
                chk("done",  int'(done),  int'(exp_done_at[rel]));
                if (!exp_busy_at[rel]) chk("stage_idle", int'(stage), 0);
            end
        end
    end

    // ------------------------------------------- memory + butterfly model
    int tw_c [4] = '{16384, 11585, 0, -11585};
    int tw_s [4] = '{0, 11585, 16384, 11585};
    int mem_re [8];
    int mem_im [8];
    bit mem_init;
    int q_ar, q_ai, q_br, q_bi, q_tw;
    int p_ar, p_ai, p_br, p_bi;
    int m_re, m_im;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 8; i++) begin
                mem_re[i] <= (i == 0) ? c_AMP : 0;
                mem_im[i] <= 0;
            end
        end else if (wr_en) begin
            mem_re[wr_addr_a] <= p_ar;
            mem_im[wr_addr_a] <= p_ai;
            mem_re[wr_addr_b] <= p_br;
            mem_im[wr_addr_b] <= p_bi;
        end
        if (rd_en) begin
            q_ar <= mem_re[rd_addr_a];
            q_ai <= mem_im[rd_addr_a];
            q_br <= mem_re[rd_addr_b];
            q_bi <= mem_im[rd_addr_b];
            q_tw <= int'(tw_addr);
        end
        if (bf_en) begin
            // W = cos - i*sin, Q14.
            m_re = (tw_c[q_tw] * q_br + tw_s[q_tw] * q_bi) >>> 14;
            m_im = (tw_c[q_tw] * q_bi - tw_s[q_tw] * q_br) >>> 14;
            p_ar <= q_ar + m_re;
            p_ai <= q_ai + m_im;
            p_br <= q_ar - m_re;
            p_bi <= q_ai - m_im;
        end
    end

    // --------------------------------------------------------------- helpers
    task automatic wait_rel(input int n);
        while (cyc - t0 < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic begin_scn();
        @(posedge clk);
        #1;
        t0     = cyc;
        mon_on = 1'b1;
    endtask

    task automatic end_scn(input string tag);
        mon_on = 1'b0;
        chk({tag, "_rd_left"}, exp_rd.size(), 0);
        chk({tag, "_wr_left"}, exp_wr.size(), 0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"},   int'(busy),      0);
        chk({tag, "_done"},   int'(done),      0);
        chk({tag, "_rd_en"},  int'(rd_en),     0);
        chk({tag, "_bf_en"},  int'(bf_en),     0);
        chk({tag, "_wr_en"},  int'(wr_en),     0);
        chk({tag, "_rd_a"},   int'(rd_addr_a), 0);
        chk({tag, "_rd_b"},   int'(rd_addr_b), 0);
        chk({tag, "_tw"},     int'(tw_addr),   0);
        chk({tag, "_wr_a"},   int'(wr_addr_a), 0);
        chk({tag, "_wr_b"},   int'(wr_addr_b), 0);
        chk({tag, "_stage"},  int'(stage),     0);
    endtask

    // ------------------------------------------------------------------ main
    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        hold     = 1'b0;
        mon_on   = 1'b0;
        mem_init = 1'b0;
        t0       = 0;

        repeat (3) @(posedge clk);
        #1;
        chk_quiet("reset");

        // start while in reset must be ignored
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_prio_busy",  int'(busy),  0);
        chk("rst_prio_rd_en", int'(rd_en), 0);
        start    = 1'b0;
        rst      = 1'b0;
        mem_init = 1'b1;
        @(posedge clk);
        #1;
        mem_init = 1'b0;

        // Plain transform with end-to-end data check
        clear_sb();
        plan(0, -1, -1);
        begin_scn();
        start = 1'b1;
        wait_rel(1);
        start = 1'b0;
        wait_rel(24);
        end_scn("plain");
        for (int i = 0; i < 8; i++) begin
            chk("e2e_re", mem_re[i], c_AMP);
            chk("e2e_im", mem_im[i], 0);
        end

        // One hold cycle during stage 0
        clear_sb();
        plan(0, 2, -1);
        begin_scn();
        start = 1'b1;
        wait_rel(1);
        start = 1'b0;
        wait_rel(2);
        hold = 1'b1;
        wait_rel(3);
        hold = 1'b0;
        wait_rel(25);
        end_scn("hold");

        // Reset during stage 1, then a fresh transform
        clear_sb();
        plan(0, -1, 8);
        plan(12, -1, -1);
        begin_scn();
        start = 1'b1;
        wait_rel(1);
        start = 1'b0;
        wait_rel(8);
        rst = 1'b1;
        wait_rel(9);
        rst = 1'b0;
        chk_quiet("abort");
        wait_rel(12);
        start = 1'b1;
        wait_rel(13);
        start = 1'b0;
        wait_rel(36);
        end_scn("abort");

        // start held high: one transform per IDLE visit
        clear_sb();
        plan(0, -1, -1);
        plan(20, -1, -1);
        begin_scn();
        start = 1'b1;
        wait_rel(40);
        start = 1'b0;
        wait_rel(50);
        end_scn("held");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
